mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port instruction/data RAM between the fetch unit and the
//  load/store unit. Accepts one request at a time and grants ties round-robin.
//  Drives the RAM index, write strobe and write data, and returns read data.
//  Sits between the control unit's fetch/MDR paths and the RAM array.
// PARAMETERS
//  ADDR_W  10  RAM index width (1024-word space)
//  DATA_W  32  word width
//  RD_LAT  1   cycles from ram_addr valid to ram_rdata valid; legal range 0..7
// PORTS
//  clk        in   1       rising-edge clock
//  clr        in   1       synchronous active-high reset
//  f_req      in   1       fetch request; held high until f_ack
//  f_addr     in   ADDR_W  fetch index; stable while f_req is high
//  f_ack      out  1       one-cycle pulse: f_rdata valid
//  f_rdata    out  DATA_W  fetched instruction word
//  d_req      in   1       data request; held high until d_ack
//  d_we       in   1       1=store, 0=load; stable while d_req is high
//  d_addr     in   ADDR_W  data index; stable while d_req is high
//  d_wdata    in   DATA_W  store data; stable while d_req is high
//  d_ack      out  1       one-cycle pulse: load data valid / store done
//  d_rdata    out  DATA_W  loaded word
//  ram_addr   out  ADDR_W  registered RAM index
//  ram_we     out  1       RAM write strobe
//  ram_wdata  out  DATA_W  registered RAM write data
//  ram_rdata  in   DATA_W  RAM read data
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset (clr sampled high): state=IDLE; f_ack=d_ack=ram_we=busy=0;
//   ram_addr=0; ram_wdata=0; f_rdata=d_rdata=0; lat_cnt=0; last=FETCH.
//  FSM states: IDLE, ACCESS, WAIT, DONE.
//  - IDLE (cycle N): if either req is high, latch the winner's addr, we and
//    wdata into ram_addr/ram_wdata and the granted-port register, then go to
//    ACCESS. If no req is high, stay in IDLE; ram_addr keeps its last value.
//  - Tie rule (both req high in IDLE): grant the port that was NOT granted
//    last. `last` updates on every grant. After reset, the first tie goes to
//    data.
//  - ACCESS (N+1): ram_we = (granted==DATA && we && !clr), high this cycle
//    only. Store: go to DONE. Load/fetch: with RD_LAT==0, capture ram_rdata
//    into the granted port's rdata at the end of ACCESS and go to DONE.
//    Otherwise load lat_cnt=RD_LAT and go to WAIT.
//  - WAIT: decrement lat_cnt each cycle. When lat_cnt==1, capture ram_rdata
//    into f_rdata or d_rdata and go to DONE. Data is captured at the end of
//    cycle N+1+RD_LAT.
//  - DONE: granted ack=1 for exactly this cycle; reqs are ignored. Go to IDLE.
//    The requester drops req on the edge that ends the ack cycle.
//  Latency: req seen in IDLE at N -> ack at N+2+RD_LAT for reads; ack at N+2
//   for stores. Back-to-back requests are therefore spaced 3+RD_LAT apart
//   (reads) or 3 apart (stores).
//  The ungranted requester waits with req held and is serviced in the next
//   IDLE cycle.
//  f_rdata/d_rdata hold their value until the next read for that port.
//  Stores do not modify d_rdata.
//  Reset mid-operation: clr has priority in every state. ram_we is forced low
//   combinationally, so no partial store occurs. No ack is issued for the
//   aborted access. The requester re-issues after reset.
//  A req that drops before its ack is a protocol violation; the result is
//   undefined and need not be handled.
// TESTING
//  1. Fetch only, RD_LAT=1: f_req=1, f_addr=0x005, RAM[5]=0x12345678 ->
//     f_ack at N+3, f_rdata=0x12345678; d_ack stays 0.
//  2. Store then load: d_we=1, d_addr=0x010, d_wdata=0xDEADBEEF ->
//     ram_we high one cycle at N+1 with ram_addr=0x010, d_ack at N+2.
//     Then a load of 0x010 returns 0xDEADBEEF.
//  3. Tie after reset: f_req and d_req both high in the same cycle ->
//     data granted first, fetch next. Holding both high gives the grant order
//     D,F,D,F... with no acks lost.
//  4. RD_LAT=0 and RD_LAT=3 builds: load ack at exactly N+2 and N+5.
//     busy is high from N+1 through the ack cycle.
//  5. clr during ACCESS of a store to 0x020 holding 0x0 -> ram_we stays 0;
//     RAM[0x20] remains 0x0; no d_ack; state IDLE, all outputs at reset values.
//  6. clr during WAIT of a fetch -> no f_ack. A re-issued fetch after
//     reset completes normally with correct data.

Source files
------------

// File: rtl/mem_port_if.sv
// Fetch, load/store and RAM-side signals of the shared memory port.
// The arbiter uses the slave view; requesters and the RAM model use the master view.
interface mem_port_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic [DATA_W-1:0] f_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output f_ack, f_rdata, d_ack, d_rdata, ram_addr, ram_we, ram_wdata, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  f_ack, f_rdata, d_ack, d_rdata, ram_addr, ram_we, ram_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between fetch and load/store; one access in flight.
// Ack at N+2+RD_LAT for reads, N+2 for stores; the losing requester holds req until served.
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input logic       clk,
    input logic       clr,
    mem_port_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic {PORT_F, PORT_D} port_t;

    state_t            state, state_nx;
    port_t             gnt, last, winner;
    logic              gnt_we;
    logic              grant;
    logic              is_store;
    logic              cap_rd;
    logic [2:0]        lat_cnt;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] f_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        winner = PORT_F;
        if (bus.f_req && bus.d_req) begin
            winner = (last == PORT_F) ? PORT_D : PORT_F;
        end else if (bus.d_req) begin
            winner = PORT_D;
        end
    end

    assign grant    = (state == IDLE) && (bus.f_req || bus.d_req);
    assign is_store = (gnt == PORT_D) && gnt_we;
    assign cap_rd   = ((state == ACCESS) && !is_store && (RD_LAT == 0)) ||
                      ((state == WAIT) && (lat_cnt == 3'd1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = ACCESS;
            ACCESS:  state_nx = (is_store || (RD_LAT == 0)) ? DONE : WAIT;
            WAIT:    if (lat_cnt == 3'd1) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            gnt         <= PORT_F;
            last        <= PORT_F;
            gnt_we      <= 1'b0;
            lat_cnt     <= 3'd0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                gnt        <= winner;
                last       <= winner;
                gnt_we     <= (winner == PORT_D) && bus.d_we;
                ram_addr_q <= (winner == PORT_D) ? bus.d_addr : bus.f_addr;
                if (winner == PORT_D) begin
                    ram_wdata_q <= bus.d_wdata;
                end
            end
            if (state == ACCESS) begin
                lat_cnt <= 3'(RD_LAT);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (cap_rd) begin
                if (gnt == PORT_D) begin
                    d_rdata_q <= bus.ram_rdata;
                end else begin
                    f_rdata_q <= bus.ram_rdata;
                end
            end
        end
    end

    // clr gates the strobe directly so an aborted store never reaches the array.
    assign bus.ram_we    = (state == ACCESS) && is_store && !clr;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.f_ack     = (state == DONE) && (gnt == PORT_F);
    assign bus.d_ack     = (state == DONE) && (gnt == PORT_D);
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Three arbiters (read latency 1, 0, 3) each with a RAM model, checked against a transaction-timeline model.
module tb_mem_port_arbiter;
    logic clk;
    logic clr;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   chk_en = 0;

    logic        f_req_a [3];
    logic [9:0]  f_addr_a [3];
    logic        d_req_a [3];
    logic        d_we_a [3];
    logic [9:0]  d_addr_a [3];
    logic [31:0] d_wdata_a [3];
    logic        f_ack_a [3];
    logic        d_ack_a [3];
    logic        ram_we_a [3];
    logic        busy_a [3];
    logic [31:0] f_rdata_a [3];
    logic [31:0] d_rdata_a [3];
    logic [31:0] ram_wdata_a [3];
    logic [9:0]  ram_addr_a [3];

    logic [31:0] ram_mem [3][1024];
    logic [9:0]  pipe [3][8];

    bit          m_act [3];
    int          m_start [3];
    int          m_ackc [3];
    bit          m_port [3];
    bit          m_we [3];
    bit          m_last [3];
    logic [9:0]  m_addr [3];
    logic [31:0] m_wdata [3];
    logic [31:0] m_f [3];
    logic [31:0] m_d [3];
    logic [31:0] m_mem [3][1024];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    function automatic logic [31:0] init_word(input int a);
        case (a)
            32'h005: return 32'h12345678;
            32'h010: return 32'h0;
            32'h020: return 32'h0;
            32'h040: return 32'hCAFEF00D;
            default: return 32'h5A5A0000 ^ a;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        localparam int PI = (L == 0) ? 0 : L - 1;
        mem_port_if #(.ADDR_W(10), .DATA_W(32)) ifc ();
        mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(L)) dut (
            .clk(clk),
            .clr(clr),
            .bus(ifc.slave)
        );
        assign ifc.f_req     = f_req_a[g];
        assign ifc.f_addr    = f_addr_a[g];
        assign ifc.d_req     = d_req_a[g];
        assign ifc.d_we      = d_we_a[g];
        assign ifc.d_addr    = d_addr_a[g];
        assign ifc.d_wdata   = d_wdata_a[g];
        assign ifc.ram_rdata = (L == 0) ? ram_mem[g][ifc.ram_addr] : ram_mem[g][pipe[g][PI]];
        assign f_ack_a[g]     = ifc.f_ack;
        assign d_ack_a[g]     = ifc.d_ack;
        assign ram_we_a[g]    = ifc.ram_we;
        assign busy_a[g]      = ifc.busy;
        assign f_rdata_a[g]   = ifc.f_rdata;
        assign d_rdata_a[g]   = ifc.d_rdata;
        assign ram_wdata_a[g] = ifc.ram_wdata;
        assign ram_addr_a[g]  = ifc.ram_addr;
    end

    // RAM arrays: synchronous write, read data RD_LAT cycles after the address.
    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 1024; a++) ram_mem[i][a] <= init_word(a);
            for (int k = 0; k < 8; k++) pipe[i][k] <= '0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (ram_we_a[i]) ram_mem[i][ram_addr_a[i]] <= ram_wdata_a[i];
                pipe[i][0] <= ram_addr_a[i];
                for (int k = 1; k < 8; k++) pipe[i][k] <= pipe[i][k-1];
            end
        end
    end

    // Reference: each access is a time window [start+1, ack] computed from the latency rules.
    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 1024; a++) m_mem[i][a] = init_word(a);
            m_act[i] = 0; m_last[i] = 0; m_f[i] = '0; m_d[i] = '0; m_addr[i] = '0;
            m_start[i] = 0; m_ackc[i] = 0; m_port[i] = 0; m_we[i] = 0; m_wdata[i] = '0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (clr) begin
                    m_act[i] = 0; m_last[i] = 0; m_f[i] = '0; m_d[i] = '0; m_addr[i] = '0;
                end else if (m_act[i]) begin
                    if (m_port[i] && m_we[i] && cyc == m_start[i] + 1)
                        m_mem[i][m_addr[i]] = m_wdata[i];
                    if (!(m_port[i] && m_we[i]) && cyc == m_ackc[i] - 1) begin
                        if (m_port[i]) m_d[i] = m_mem[i][m_addr[i]];
                        else m_f[i] = m_mem[i][m_addr[i]];
                    end
                    if (cyc == m_ackc[i]) m_act[i] = 0;
                end else if (f_req_a[i] || d_req_a[i]) begin
                    m_port[i]  = (f_req_a[i] && d_req_a[i]) ? !m_last[i] : d_req_a[i];
                    m_we[i]    = m_port[i] && d_we_a[i];
                    m_addr[i]  = m_port[i] ? d_addr_a[i] : f_addr_a[i];
                    m_wdata[i] = d_wdata_a[i];
                    m_last[i]  = m_port[i];
                    m_act[i]   = 1;
                    m_start[i] = cyc;
                    m_ackc[i]  = cyc + 2 + (m_we[i] ? 0 : lat_of(i));
                end
            end
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got 0x%08h, expected 0x%08h", nm, inst, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    logic exp_we;
                    exp_we = m_act[i] && (cyc == m_start[i] + 1) && m_port[i] && m_we[i] && !clr;
                    chk("busy", i, busy_a[i], m_act[i]);
                    chk("f_ack", i, f_ack_a[i], m_act[i] && cyc == m_ackc[i] && !m_port[i]);
                    chk("d_ack", i, d_ack_a[i], m_act[i] && cyc == m_ackc[i] && m_port[i]);
                    chk("ram_we", i, ram_we_a[i], exp_we);
                    chk("ram_addr", i, ram_addr_a[i], m_addr[i]);
                    chk("f_rdata", i, f_rdata_a[i], m_f[i]);
                    chk("d_rdata", i, d_rdata_a[i], m_d[i]);
                    if (exp_we) chk("ram_wdata", i, ram_wdata_a[i], m_wdata[i]);
                end
            end
        end
    end

    task automatic txn(input int i, input bit port, input bit we, input logic [9:0] addr,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd);
        int n;
        bit got;
        n = cyc; got = 0; lat = -1; rd = '0;
        if (port) begin
            d_we_a[i] = we; d_addr_a[i] = addr; d_wdata_a[i] = wd; d_req_a[i] = 1'b1;
        end else begin
            f_addr_a[i] = addr; f_req_a[i] = 1'b1;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (port ? d_ack_a[i] : f_ack_a[i]) begin
                got = 1;
                lat = cyc - n;
                rd  = port ? d_rdata_a[i] : f_rdata_a[i];
            end
        end
        if (!got) chk("ack_timeout", i, 0, 1);
        @(posedge clk); #1;
        d_req_a[i] = 1'b0; f_req_a[i] = 1'b0; d_we_a[i] = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] rd;
        bit saw;
        int nack;
        int seq [4];
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f_req_a[i] = 0; f_addr_a[i] = '0; d_req_a[i] = 0; d_we_a[i] = 0;
            d_addr_a[i] = '0; d_wdata_a[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        chk_en = 1;
        chk("rst_busy", 0, busy_a[0], 0);
        chk("rst_ram_addr", 0, ram_addr_a[0], 0);
        chk("rst_f_rdata", 0, f_rdata_a[0], 0);
        chk("rst_ram_we", 0, ram_we_a[0], 0);

        // Fetch of word 5.
        txn(0, 0, 0, 10'h005, 32'h0, lat, rd);
        chk("t1_lat", 0, lat, 3);
        chk("t1_fdata", 0, rd, 32'h12345678);

        // Store to 0x010, strobe and ack timing by hand.
        d_we_a[0] = 1; d_addr_a[0] = 10'h010; d_wdata_a[0] = 32'hDEADBEEF; d_req_a[0] = 1;
        @(negedge clk); chk("t2_we_N", 0, ram_we_a[0], 0);
        @(negedge clk); chk("t2_we_N1", 0, ram_we_a[0], 1);
        chk("t2_addr_N1", 0, ram_addr_a[0], 10'h010);
        chk("t2_wdata_N1", 0, ram_wdata_a[0], 32'hDEADBEEF);
        @(negedge clk); chk("t2_ack_N2", 0, d_ack_a[0], 1);
        chk("t2_we_N2", 0, ram_we_a[0], 0);
        @(posedge clk); #1 d_req_a[0] = 0; d_we_a[0] = 0;
        txn(0, 1, 0, 10'h010, 32'h0, lat, rd);
        chk("t2_load_lat", 0, lat, 3);
        chk("t2_load_data", 0, rd, 32'hDEADBEEF);

        // Reset during ACCESS of a store.
        d_we_a[0] = 1; d_addr_a[0] = 10'h020; d_wdata_a[0] = 32'hA5A5A5A5; d_req_a[0] = 1;
        @(posedge clk); #1 clr = 1'b1;
        @(negedge clk); chk("t5_we_in_clr", 0, ram_we_a[0], 0);
        @(posedge clk); #1 clr = 1'b0; d_req_a[0] = 0; d_we_a[0] = 0;
        chk("t5_busy", 0, busy_a[0], 0);
        chk("t5_ram_addr", 0, ram_addr_a[0], 0);
        chk("t5_f_rdata", 0, f_rdata_a[0], 0);
        chk("t5_d_rdata", 0, d_rdata_a[0], 0);
        saw = 0;
        repeat (6) begin @(negedge clk); if (d_ack_a[0]) saw = 1; end
        chk("t5_no_ack", 0, saw, 0);
        chk("t5_ram20", 0, ram_mem[0][10'h020], 32'h0);

        // Tie right after reset: data first, then alternate.
        @(posedge clk); #1;
        f_addr_a[0] = 10'h005; d_addr_a[0] = 10'h040; d_we_a[0] = 0;
        f_req_a[0] = 1; d_req_a[0] = 1;
        nack = 0;
        for (int k = 0; k < 60 && nack < 4; k++) begin
            @(negedge clk);
            if (d_ack_a[0]) begin seq[nack] = 1; nack++; end
            else if (f_ack_a[0]) begin seq[nack] = 0; nack++; end
        end
        @(posedge clk); #1 f_req_a[0] = 0; d_req_a[0] = 0;
        chk("t3_nack", 0, nack, 4);
        chk("t3_g0_D", 0, seq[0], 1);
        chk("t3_g1_F", 0, seq[1], 0);
        chk("t3_g2_D", 0, seq[2], 1);
        chk("t3_g3_F", 0, seq[3], 0);

        // Reset during WAIT of a fetch, then re-issue.
        repeat (2) @(posedge clk); #1;
        f_addr_a[0] = 10'h005; f_req_a[0] = 1;
        @(posedge clk); #1;
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0; f_req_a[0] = 0;
        saw = 0;
        repeat (6) begin @(negedge clk); if (f_ack_a[0]) saw = 1; end
        chk("t6_no_ack", 0, saw, 0);
        chk("t6_f_rdata_clr", 0, f_rdata_a[0], 0);
        @(posedge clk); #1;
        txn(0, 0, 0, 10'h005, 32'h0, lat, rd);
        chk("t6_lat", 0, lat, 3);
        chk("t6_data", 0, rd, 32'h12345678);

        // Other read latencies.
        txn(1, 1, 0, 10'h040, 32'h0, lat, rd);
        chk("t4_lat0", 1, lat, 2);
        chk("t4_lat0_data", 1, rd, 32'hCAFEF00D);
        txn(2, 1, 0, 10'h040, 32'h0, lat, rd);
        chk("t4_lat3", 2, lat, 5);
        chk("t4_lat3_data", 2, rd, 32'hCAFEF00D);
        txn(2, 0, 0, 10'h005, 32'h0, lat, rd);
        chk("t4_lat3_fetch", 2, lat, 5);
        chk("t4_lat3_fdata", 2, rd, 32'h12345678);
        txn(2, 1, 1, 10'h011, 32'h0BADF00D, lat, rd);
        chk("t4_lat3_store", 2, lat, 2);
        txn(1, 1, 1, 10'h011, 32'h600DCAFE, lat, rd);
        txn(1, 0, 0, 10'h011, 32'h0, lat, rd);
        chk("t4_lat0_fetch", 1, lat, 2);
        chk("t4_lat0_fdata", 1, rd, 32'h600DCAFE);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
